// File: rtl/ahb_lite_master_bridge.sv
// ahb_lite_master_bridge
//   Single-outstanding AHB-Lite master. Converts a CPU load/store request into one
//   AHB-Lite SINGLE transfer at a time and returns a one-cycle completion pulse with
//   read data and error status. A data-phase watchdog forces an error completion
//   when a slave holds HREADY low for TIMEOUT consecutive cycles.
//
// Ports
//   HCLK, HRESET             clock, asynchronous active-high reset
//   cpu_req/addr/we/size/wdata  CPU request (taken when cpu_req && cpu_ready)
//   cpu_ready                 combinational: bridge idle and not in reset
//   cpu_rvalid/rdata/err      registered completion pulse, load data, error flag
//   HADDR..HWRITE             AHB-Lite master outputs (registered or constant)
//   HRDATA, HREADY, HRESP     AHB-Lite slave response inputs

module ahb_lite_master_bridge #(
    parameter int unsigned TIMEOUT   = 16,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cpu_req,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_we,
    input  logic [1:0]  cpu_size,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    output logic        cpu_err,
    output logic [31:0] HADDR,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    output logic        HWRITE,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    localparam int unsigned WdogW = $clog2(TIMEOUT + 1);
    localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT - 1);

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    state_e            state_q, state_d;
    logic [31:0]       haddr_q, haddr_d;
    logic              hwrite_q, hwrite_d;
    logic [2:0]        hsize_q, hsize_d;
    logic [1:0]        htrans_q, htrans_d;
    logic [31:0]       hwdata_q, hwdata_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rvalid_q, rvalid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [WdogW-1:0]  wdog_q, wdog_d;
    logic              misaligned;

    assign cpu_ready = (state_q == StIdle) && !HRESET;

    always_comb begin
        unique case (cpu_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = cpu_addr[0];
            2'b10:   misaligned = |cpu_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        htrans_d = htrans_q;
        hwdata_d = hwdata_q;
        wdata_d  = wdata_q;
        wdog_d   = wdog_q;
        // Completion outputs are pulses; they fall back to zero unless completing.
        rvalid_d = 1'b0;
        rdata_d  = '0;
        err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                htrans_d = TransIdle;
                if (cpu_req && cpu_ready) begin
                    if (misaligned) begin
                        // Rejected without touching the bus.
                        rvalid_d = 1'b1;
                        err_d    = 1'b1;
                    end else begin
                        state_d  = StAddr;
                        haddr_d  = cpu_addr;
                        hwrite_d = cpu_we;
                        hsize_d  = {1'b0, cpu_size};
                        htrans_d = TransNonseq;
                        wdata_d  = cpu_wdata;
                    end
                end
            end
            StAddr: begin
                if (HREADY) begin
                    state_d  = StData;
                    htrans_d = TransIdle;
                    if (hwrite_q) begin
                        hwdata_d = wdata_q;
                    end
                end
            end
            StData: begin
                if (HREADY) begin
                    state_d  = StIdle;
                    rvalid_d = 1'b1;
                    err_d    = HRESP;
                    // HRDATA is only looked at on the completing edge of a good load.
                    rdata_d  = (!hwrite_q && !HRESP) ? HRDATA : '0;
                    wdog_d   = '0;
                end else if (wdog_q == WdogLast) begin
                    state_d  = StIdle;
                    rvalid_d = 1'b1;
                    err_d    = 1'b1;
                    wdog_d   = '0;
                end else begin
                    wdog_d = wdog_q + WdogW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= StIdle;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            hsize_q  <= 3'b010;
            htrans_q <= TransIdle;
            hwdata_q <= '0;
            wdata_q  <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            wdog_q   <= '0;
        end else begin
            state_q  <= state_d;
            haddr_q  <= haddr_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            htrans_q <= htrans_d;
            hwdata_q <= hwdata_d;
            wdata_q  <= wdata_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            wdog_q   <= wdog_d;
        end
    end

    assign HADDR      = haddr_q;
    assign HWRITE     = hwrite_q;
    assign HSIZE      = hsize_q;
    assign HTRANS     = htrans_q;
    assign HWDATA     = hwdata_q;
    assign HBURST     = 3'b000;
    assign HMASTLOCK  = 1'b0;
    assign HPROT      = HPROT_VAL;
    assign cpu_rvalid = rvalid_q;
    assign cpu_rdata  = rdata_q;
    assign cpu_err    = err_q;

endmodule
